edg_zbt_writer: RTL

- Downstream consumer of the edge-detect wrapper.
- Captures each processed 36-bit pixel pair (two RGB666 pixels) on the even-hcount cycles where the pair is valid, and tags it with a frame-buffer address.
- Buffers pairs in a small FIFO and writes them into ZBT memory through a req/gnt port on the memory arbiter.
- Tracks frames and reports completion and overflow to the display/control logic.

---
 rtl/edg_zbt_writer_pkg.sv | 20 ++
 rtl/edg_zbt_writer_if.sv | 16 +
 rtl/edg_wr_fifo.sv | 53 +++++
 rtl/edg_zbt_writer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/edg_zbt_writer_pkg.sv
// Shared types and constants for the edge-detect ZBT frame writer.
package edg_zbt_writer_pkg;

  localparam int PIX_W        = 18;
  localparam int PAIR_W       = 2 * PIX_W;
  // Entry address field is sized for the ZBT part; ADDR_W must not exceed it.
  localparam int ENTRY_ADDR_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [PAIR_W-1:0]       data;
  } entry_t;

endpackage

// File: rtl/edg_zbt_writer_if.sv
// Write port from the frame writer to the ZBT memory arbiter.
interface edg_zbt_writer_if #(
  parameter int ADDR_W = 19
);
  import edg_zbt_writer_pkg::*;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PAIR_W-1:0] mem_data;

  modport master (output mem_req, output mem_we, output mem_addr, output mem_data, input mem_gnt);
  modport slave  (input mem_req, input mem_we, input mem_addr, input mem_data, output mem_gnt);

endinterface

// File: rtl/edg_wr_fifo.sv
// Synchronous FIFO for address/data write entries. A push into a full FIFO
// is accepted only when a pop occurs in the same cycle; otherwise o_drop flags it.
module edg_wr_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage needs no reset; an empty FIFO never exposes it.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/edg_zbt_writer.sv
// Captures processed pixel pairs into a FIFO and writes them to ZBT memory.
// Define ZBT_DOUBLE_BUF_EN to alternate frames between two buffers.
//
// state     | meaning
// ST_IDLE   | waiting for enable at frame start; FIFO empty
// ST_ACTIVE | capturing pairs of the current frame
// ST_DRAIN  | capture finished, emptying FIFO into memory
module edg_zbt_writer
  import edg_zbt_writer_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CAP_START  = 4,
  parameter int ADDR_W     = ENTRY_ADDR_W,
  parameter int FIFO_DEPTH = 8,
  parameter int BUF0_BASE  = 0,
  parameter int BUF1_BASE  = 262144
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [10:0]       i_hcount,
  input  logic [9:0]        i_vcount,
  input  logic [PAIR_W-1:0] i_two_proc_pixs,
  edg_zbt_writer_if.master  mem,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_buf_sel
);

  localparam int N_PAIRS = H_ACTIVE * V_ACTIVE / 2;
  localparam int CNT_W   = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_PAIRS - 1);
  localparam logic [10:0]       CAP_LO   = 11'(CAP_START);
  localparam logic [10:0]       CAP_HI   = 11'(CAP_START + H_ACTIVE);
  localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(BUF0_BASE);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(BUF1_BASE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_overflow;
  logic              r_frame_done;
  logic              w_frame_start;
  logic              w_start;
  logic              w_capture;
  logic              w_last;
  logic              w_done;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_buf_idx;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_pair_addr;
  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  assign w_frame_start = (i_hcount == '0) && (i_vcount == '0);
  assign w_start       = (r_state == ST_IDLE) && i_enable && w_frame_start;

  // Capture is live in the start cycle itself, with the counter seen as cleared.
  assign w_capture = ((r_state == ST_ACTIVE) || w_start) && !i_hcount[0] &&
                     (i_hcount >= CAP_LO) && (i_hcount < CAP_HI) && (i_vcount < V_LIM);
  assign w_cnt     = w_start ? '0 : r_cnt;
  assign w_last    = w_capture && (w_cnt == LAST_CNT);

`ifdef ZBT_DOUBLE_BUF_EN
  logic r_cur_buf;
  logic r_buf_sel;

  // r_cur_buf resets to 1 so that the first frame after reset lands in buffer 0.
  assign w_buf_idx = w_start ? ~r_cur_buf : r_cur_buf;
  assign o_buf_sel = r_buf_sel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur_buf <= 1'b1;
      r_buf_sel <= 1'b0;
    end else begin
      if (w_start) r_cur_buf <= ~r_cur_buf;
      if (w_done)  r_buf_sel <= r_cur_buf;
    end
  end
`else
  assign w_buf_idx = 1'b0;
  assign o_buf_sel = 1'b0;
`endif

  assign w_base      = w_buf_idx ? BASE1 : BASE0;
  assign w_pair_addr = w_base + ADDR_W'(w_cnt);

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.addr = ENTRY_ADDR_W'(w_pair_addr);
    w_push_entry.data = i_two_proc_pixs;
  end

  edg_wr_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_capture),
    .i_din   (w_push_entry),
    .i_pop   (mem.mem_gnt),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = w_last ? ST_DRAIN : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_last || w_frame_start) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done;
      // Dropped pairs still advance the counter so later pairs keep their slot.
      if (w_capture)    r_cnt <= w_cnt + CNT_W'(1);
      else if (w_start) r_cnt <= '0;
      if (w_start)
        r_overflow <= 1'b0;
      else if (w_drop || ((r_state == ST_ACTIVE) && w_frame_start))
        r_overflow <= 1'b1;
    end
  end

  assign mem.mem_req  = ~w_empty;
  assign mem.mem_we   = ~w_empty;
  assign mem.mem_addr = w_empty ? '0 : ADDR_W'(w_head.addr);
  assign mem.mem_data = w_empty ? '0 : w_head.data;

  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;

endmodule
